mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencer for the ROM → multiply → RAM datapath.
- On a start pulse it walks N operand-address pairs, issues the two ROM reads, registers the product, and writes it to consecutive RAM addresses.
- Exposes a start/busy/done handshake so a top level or a bench can drive whole batches instead of poking the ROM addresses by hand.

Parameters:
- ADDR_W, 3, ROM and RAM address width (wraps mod 2^ADDR_W).
- DATA_W, 8, operand and RAM word width.
- CNT_W, 4, width of the pair-count input (max N = 2^ADDR_W = 8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- base1  in  ADDR_W  first ROM address for operand 1.
- base2  in  ADDR_W  first ROM address for operand 2.
- wr_base  in  ADDR_W  first RAM write address.
- count  in  CNT_W  number of pairs N, valid range 0..8.
- rom_addr1  out  ADDR_W  ROM port-1 address.
- rom_addr2  out  ADDR_W  ROM port-2 address.
- rom_data1  in  DATA_W  ROM port-1 data, 1-cycle synchronous latency.
- rom_data2  in  DATA_W  ROM port-2 data, 1-cycle synchronous latency.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- result  out  DATA_W  last value written to RAM; held between writes.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at batch completion.

Behaviour:
- Reset values: state=IDLE; rom_addr1=0, rom_addr2=0, ram_addr=0, ram_wdata=0, result=0; ram_we=0, busy=0, done=0; index i=0.
- FSM states:
  - IDLE: on start, latch base1, base2, wr_base and count (clamped to 8 if >8). count=0 → DONE; else → FETCH.
  - FETCH: drive rom_addr1=base1+i and rom_addr2=base2+i, both mod 2^ADDR_W → WAIT.
  - WAIT: ROM data valid at end of this cycle → MUL.
  - MUL: prod = rom_data1*rom_data2 (2*DATA_W bits, unsigned), registered → WRITE.
  - WRITE: ram_we=1 for exactly one cycle; ram_addr=wr_base+i (wrap); ram_wdata=prod[DATA_W-1:0]; result updated the same cycle. If i==N-1 → DONE; else i++ → FETCH.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Timing:
  - 4 cycles per pair.
  - First ram_we is 4 cycles after the start cycle.
  - done is asserted the cycle after the final write.
  - N pairs → done at start+4N+1; N=0 → done at start+1.
- Boundary conditions:
  - start while busy is ignored; latched parameters stay stable for the whole batch.
  - Address wrap: base1=6, N=4 reads addresses 6,7,0,1.
  - Reset asserted mid-batch: ram_we drops asynchronously; the partial batch is abandoned; no done pulse.
  - start in the same cycle that DONE returns to IDLE is not accepted. A start is accepted only when sampled in IDLE.
- rom_addr1/rom_addr2 hold their last value outside FETCH.

Optional Feature:
- Macro MUL_SAT_EN.
- Defined: if prod[2*DATA_W-1:DATA_W] != 0, ram_wdata and result = all-ones (0xFF); an extra output sat_flag (1 bit) pulses with the matching ram_we.
- Undefined: plain truncation to the low DATA_W bits; no sat_flag port.

Decomposition:
- Package mul_seq_pkg holds:
  - state enum/localparams S_IDLE, S_FETCH, S_WAIT, S_MUL, S_WRITE, S_DONE;
  - MAX_PAIRS = 8;
  - widths shared with the top-level datapath.
- One natural sub-module, addr_gen: holds i and produces the three wrapped addresses from the latched bases; reset by the controller on start.
- FSM and product register stay in mul_seq_ctrl.

Test Plan:
- Bench ROM model rom[k]=k+1.
- Single pair: start, base1=1, base2=2, wr_base=0, count=1 → ram_we once at addr 0 with data 0x06; result=0x06; done at cycle 5 after start.
- Batch with wrap: base1=6, base2=0, wr_base=7, count=3 → writes {addr7:0x07, addr0:0x10, addr1:0x03}; done at start+13.
- count=0 → no ram_we; done pulses at start+1; busy never asserted.
- Ignored start and reset: start re-pulsed mid-batch → ignored, write count unchanged. Reset=0 pulsed during the 2nd pair of a count=4 batch → ram_we low immediately; all outputs at reset values; no done; a fresh start then runs normally.
- Overflow: ROM words 0x20 and 0x10 → product 0x0200; ram_wdata=0x00 without MUL_SAT_EN; 0xFF with sat_flag=1 with MUL_SAT_EN.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared states, default widths and batch-size helper for the ROM-multiply-RAM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_seq_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 4;

   // Largest batch: one pair per addressable ROM/RAM word.
   function automatic int max_pairs(input int addr_w);
      return 1 << addr_w;
   endfunction

   localparam int MAX_PAIRS = max_pairs(ADDR_W_DEF);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_MUL   = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/mul_seq_ctrl_addr_gen.sv
// addr_gen: latches the batch bases and pair index, produces wrapped ROM read and RAM write addresses.
// Latency: ROM addresses valid combinationally during FETCH and held afterwards; index steps one cycle after i_adv.
// Backpressure: none; the controller decides when to load and advance.
module addr_gen #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_adv,
   input  logic              i_fetch,
   input  logic [ADDR_W-1:0] i_base1,
   input  logic [ADDR_W-1:0] i_base2,
   input  logic [ADDR_W-1:0] i_wr_base,
   output logic [ADDR_W-1:0] o_rom_addr1,
   output logic [ADDR_W-1:0] o_rom_addr2,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [ADDR_W-1:0] o_idx
);

   logic [ADDR_W-1:0] r_base1;
   logic [ADDR_W-1:0] r_base2;
   logic [ADDR_W-1:0] r_wr_base;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_hold1;
   logic [ADDR_W-1:0] r_hold2;
   logic [ADDR_W-1:0] w_addr1;
   logic [ADDR_W-1:0] w_addr2;

   // Sums wrap naturally at ADDR_W bits, giving the mod-2^ADDR_W walk.
   assign w_addr1 = r_base1 + r_idx;
   assign w_addr2 = r_base2 + r_idx;

   // Bases are frozen for the whole batch; index restarts at 0 on every accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base1   <= '0;
         r_base2   <= '0;
         r_wr_base <= '0;
         r_idx     <= '0;
      end else if (i_load) begin
         r_base1   <= i_base1;
         r_base2   <= i_base2;
         r_wr_base <= i_wr_base;
         r_idx     <= '0;
      end else if (i_adv) begin
         r_idx     <= r_idx + 1'b1;
      end
   end

   // Remember the FETCH address so the ROM ports stay put outside FETCH, even across a new start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold1 <= '0;
         r_hold2 <= '0;
      end else if (i_fetch) begin
         r_hold1 <= w_addr1;
         r_hold2 <= w_addr2;
      end
   end

   assign o_rom_addr1 = i_fetch ? w_addr1 : r_hold1;
   assign o_rom_addr2 = i_fetch ? w_addr2 : r_hold2;
   assign o_ram_addr  = r_wr_base + r_idx;
   assign o_idx       = r_idx;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: walks N ROM operand pairs, multiplies them and writes products to consecutive RAM words.
// Latency: 4 cycles per pair; first ram_we at start+4, done at start+4N+1 (start+1 when N=0).
// Backpressure: none; start is honoured only in IDLE, ignored while busy or in DONE.
// Build option MUL_SAT_EN: overflowing products saturate to all-ones and sat_flag pulses with ram_we.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base1,
   input  logic [ADDR_W-1:0] base2,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] rom_addr1,
   output logic [ADDR_W-1:0] rom_addr2,
   input  logic [DATA_W-1:0] rom_data1,
   input  logic [DATA_W-1:0] rom_data2,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done
`ifdef MUL_SAT_EN
   ,
   output logic              sat_flag
`endif
);

   // Without saturation the high half of the product is never observed, so it is not kept.
`ifdef MUL_SAT_EN
   localparam int PROD_W = 2 * DATA_W;
`else
   localparam int PROD_W = DATA_W;
`endif
   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(max_pairs(ADDR_W));

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_last;
   logic [PROD_W-1:0] r_prod;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] w_wdata;
   logic [CNT_W-1:0]  w_count_n;
   logic [ADDR_W-1:0] w_idx;
   logic              w_load;
   logic              w_adv;
   logic              w_fetch;
   logic              w_is_last;

   // Out-of-range counts are clamped to one full sweep of the address space.
   assign w_count_n = (count > MAX_N) ? MAX_N : count;
   assign w_is_last = (w_idx == r_last);

   addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_adv       (w_adv),
      .i_fetch     (w_fetch),
      .i_base1     (base1),
      .i_base2     (base2),
      .i_wr_base   (wr_base),
      .o_rom_addr1 (rom_addr1),
      .o_rom_addr2 (rom_addr2),
      .o_ram_addr  (ram_addr),
      .o_idx       (w_idx)
   );

   // State register; reset abandons any batch in flight without a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and Moore strobes; all strobes decode r_state so reset clears them at once.
   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_adv   = 1'b0;
      w_fetch = 1'b0;
      ram_we  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = (count == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            busy    = 1'b1;
            w_fetch = 1'b1;
            w_next  = S_WAIT;
         end
         S_WAIT: begin
            busy   = 1'b1;
            w_next = S_MUL;
         end
         S_MUL: begin
            busy   = 1'b1;
            w_next = S_WRITE;
         end
         S_WRITE: begin
            busy   = 1'b1;
            ram_we = 1'b1;
            if (w_is_last) begin
               w_next = S_DONE;
            end else begin
               w_adv  = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Index of the final pair, captured with the rest of the batch parameters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= '0;
      end else if (w_load) begin
         r_last <= ADDR_W'(w_count_n - CNT_W'(1));
      end
   end

   // ROM data is stable through MUL because the ROM addresses are held after FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prod <= '0;
      end else if (r_state == S_MUL) begin
         r_prod <= PROD_W'(rom_data1) * PROD_W'(rom_data2);
      end
   end

`ifdef MUL_SAT_EN
   logic w_ovf;
   assign w_ovf    = |r_prod[PROD_W-1:DATA_W];
   assign w_wdata  = w_ovf ? {DATA_W{1'b1}} : r_prod[DATA_W-1:0];
   assign sat_flag = ram_we & w_ovf;
`else
   assign w_wdata  = r_prod;
`endif

   // Keep the last written word so result holds between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result <= '0;
      end else if (ram_we) begin
         r_result <= w_wdata;
      end
   end

   assign ram_wdata = w_wdata;
   // result tracks the word being written in the WRITE cycle itself.
   assign result    = ram_we ? w_wdata : r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed batches against mul_seq_ctrl with a 1-cycle ROM model rom[k]=k+1.
// Latency: checks write/done cycle offsets relative to the start cycle.
// Backpressure: n/a; a negedge monitor records every RAM write, done pulse and first busy cycle.
module tb_mul_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [2:0] base1 = '0;
   logic [2:0] base2 = '0;
   logic [2:0] wr_base = '0;
   logic [3:0] count = '0;
   logic [2:0] rom_addr1;
   logic [2:0] rom_addr2;
   logic [7:0] rom_data1 = '0;
   logic [7:0] rom_data2 = '0;
   logic       ram_we;
   logic [2:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] result;
   logic       busy;
   logic       done;
`ifdef MUL_SAT_EN
   logic       sat_flag;
   logic       sat_q[$];
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int busy_first = -1;
   int start_cyc = 0;

   logic [7:0] rom_mem [8];
   logic [2:0] wr_addr_q[$];
   logic [2:0] rd1_q[$];
   logic [7:0] wr_data_q[$];
   int         wr_cyc_q[$];

   mul_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base1     (base1),
      .base2     (base2),
      .wr_base   (wr_base),
      .count     (count),
      .rom_addr1 (rom_addr1),
      .rom_addr2 (rom_addr2),
      .rom_data1 (rom_data1),
      .rom_data2 (rom_data2),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .result    (result),
      .busy      (busy),
      .done      (done)
`ifdef MUL_SAT_EN
      ,
      .sat_flag  (sat_flag)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter; value seen during a cycle is the number of elapsed rising edges
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM, one cycle of read latency on both ports
   always @(posedge clk) begin
      rom_data1 <= rom_mem[rom_addr1];
      rom_data2 <= rom_mem[rom_addr2];
   end

   // Monitor sampling DUT outputs mid-cycle
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         wr_addr_q.push_back(ram_addr);
         wr_data_q.push_back(ram_wdata);
         wr_cyc_q.push_back(cyc);
         rd1_q.push_back(rom_addr1);
`ifdef MUL_SAT_EN
         sat_q.push_back(sat_flag);
`endif
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (busy === 1'b1 && busy_first < 0) busy_first = cyc;
   end

   task automatic rom_default();
      for (int k = 0; k < 8; k++) rom_mem[k] = 8'(k + 1);
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      rd1_q.delete();
`ifdef MUL_SAT_EN
      sat_q.delete();
`endif
      done_cnt   = 0;
      done_cyc   = -1;
      busy_first = -1;
   endtask

   task automatic do_start(input logic [2:0] b1, input logic [2:0] b2,
                           input logic [2:0] wb, input logic [3:0] n);
      @(negedge clk); #1;
      clear_mon();
      base1 = b1; base2 = b2; wr_base = wb; count = n;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rst_busy_done got=%b exp=00", {busy, done}); end
      checks++; if ({rom_addr1, rom_addr2, ram_addr} !== 9'h0) begin failures++; $display("FAIL rst_addrs got=%h exp=0", {rom_addr1, rom_addr2, ram_addr}); end
      checks++; if ({ram_wdata, result} !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {ram_wdata, result}); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done_cnt != 0) begin failures++; $display("FAIL rst_idle busy=%b done_cnt=%0d exp 0/0", busy, done_cnt); end
   endtask

   task automatic test_single_pair();
      bit ok;
      do_start(3'd1, 3'd2, 3'd0, 4'd1);
      wait_done(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
      checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL single_wr_count got=%0d exp=1", wr_addr_q.size()); end
      if (wr_addr_q.size() == 1) begin
         checks++; if (wr_addr_q[0] !== 3'd0 || wr_data_q[0] !== 8'h06) begin failures++; $display("FAIL single_write got=%0d:%h exp=0:06", wr_addr_q[0], wr_data_q[0]); end
         checks++; if (wr_cyc_q[0] != start_cyc + 4) begin failures++; $display("FAIL single_wr_cycle got=%0d exp=%0d", wr_cyc_q[0], start_cyc + 4); end
`ifdef MUL_SAT_EN
         checks++; if (sat_q[0] !== 1'b0) begin failures++; $display("FAIL single_sat got=%b exp=0", sat_q[0]); end
`endif
      end
      checks++; if (done_cyc != start_cyc + 5) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 5); end
      checks++; if (busy_first != start_cyc + 1) begin failures++; $display("FAIL single_busy_first got=%0d exp=%0d", busy_first, start_cyc + 1); end
      checks++; if (result !== 8'h06) begin failures++; $display("FAIL single_result got=%h exp=06", result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_at_done got=%b exp=0", busy); end
   endtask

   task automatic test_wrap_batch();
      bit ok;
      logic [2:0] exp_a [3] = '{3'd7, 3'd0, 3'd1};
      logic [7:0] exp_d [3] = '{8'h07, 8'h10, 8'h03};
      logic [2:0] exp_r [3] = '{3'd6, 3'd7, 3'd0};
      do_start(3'd6, 3'd0, 3'd7, 4'd3);
      wait_done(30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no_done exp=done"); end
      checks++; if (wr_addr_q.size() != 3) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=3", wr_addr_q.size()); end
      if (wr_addr_q.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            checks++; if (wr_addr_q[k] !== exp_a[k] || wr_data_q[k] !== exp_d[k]) begin failures++; $display("FAIL wrap_write%0d got=%0d:%h exp=%0d:%h", k, wr_addr_q[k], wr_data_q[k], exp_a[k], exp_d[k]); end
            checks++; if (rd1_q[k] !== exp_r[k]) begin failures++; $display("FAIL wrap_rom_addr%0d got=%0d exp=%0d", k, rd1_q[k], exp_r[k]); end
            checks++; if (wr_cyc_q[k] != start_cyc + 4 * (k + 1)) begin failures++; $display("FAIL wrap_wr_cycle%0d got=%0d exp=%0d", k, wr_cyc_q[k], start_cyc + 4 * (k + 1)); end
         end
      end
      checks++; if (done_cyc != start_cyc + 13) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 13); end
      checks++; if (result !== 8'h03) begin failures++; $display("FAIL wrap_result got=%h exp=03", result); end
   endtask

   task automatic test_clamp();
      bit ok;
      logic [7:0] exp_d [8] = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd25, 8'd36, 8'd49, 8'd64};
      do_start(3'd0, 3'd0, 3'd0, 4'd15);
      wait_done(60, ok);
      checks++; if (!ok) begin failures++; $display("FAIL clamp_timeout got=no_done exp=done"); end
      checks++; if (wr_addr_q.size() != 8) begin failures++; $display("FAIL clamp_wr_count got=%0d exp=8", wr_addr_q.size()); end
      if (wr_addr_q.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            checks++; if (wr_addr_q[k] !== 3'(k) || wr_data_q[k] !== exp_d[k]) begin failures++; $display("FAIL clamp_write%0d got=%0d:%h exp=%0d:%h", k, wr_addr_q[k], wr_data_q[k], k, exp_d[k]); end
         end
      end
      checks++; if (done_cyc != start_cyc + 33) begin failures++; $display("FAIL clamp_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 33); end
   endtask

   task automatic test_count_zero();
      bit ok;
      do_start(3'd3, 3'd3, 3'd3, 4'd0);
      wait_done(10, ok);
      repeat (6) @(negedge clk);
      #1;
      checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got=no_done exp=done"); end
      checks++; if (done_cyc != start_cyc + 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 1); end
      checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL zero_wr_count got=%0d exp=0", wr_addr_q.size()); end
      checks++; if (busy_first != -1) begin failures++; $display("FAIL zero_busy got_first=%0d exp=never", busy_first); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_ignored_start();
      bit ok;
      do_start(3'd0, 3'd1, 3'd2, 4'd2);
      @(negedge clk); #1;
      base1 = 3'd5; base2 = 3'd5; wr_base = 3'd5; count = 4'd8;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_done(30, ok);
      repeat (10) @(negedge clk);
      #1;
      checks++; if (!ok) begin failures++; $display("FAIL ign_timeout got=no_done exp=done"); end
      checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL ign_wr_count got=%0d exp=2", wr_addr_q.size()); end
      if (wr_addr_q.size() == 2) begin
         checks++; if (wr_addr_q[0] !== 3'd2 || wr_data_q[0] !== 8'h02) begin failures++; $display("FAIL ign_write0 got=%0d:%h exp=2:02", wr_addr_q[0], wr_data_q[0]); end
         checks++; if (wr_addr_q[1] !== 3'd3 || wr_data_q[1] !== 8'h06) begin failures++; $display("FAIL ign_write1 got=%0d:%h exp=3:06", wr_addr_q[1], wr_data_q[1]); end
      end
      checks++; if (done_cnt != 1 || done_cyc != start_cyc + 9) begin failures++; $display("FAIL ign_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, start_cyc + 9); end

      // start raised during the DONE cycle must be dropped
      do_start(3'd1, 3'd2, 3'd0, 4'd1);
      wait_done(20, ok);
      checks++; if (!ok || done_cyc != start_cyc + 5) begin failures++; $display("FAIL dcs_first_done got=%0d exp=%0d", done_cyc, start_cyc + 5); end
      clear_mon();
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      checks++; if (wr_addr_q.size() != 0 || done_cnt != 0 || busy_first != -1) begin failures++; $display("FAIL dcs_accepted got wr=%0d done=%0d busy_first=%0d exp=0/0/-1", wr_addr_q.size(), done_cnt, busy_first); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_start(3'd6, 3'd0, 3'd0, 4'd4);
      repeat (7) @(negedge clk);
      #1;
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL rmid_pre_we got=%b exp=1", ram_we); end
      reset = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_strobes got=%b%b%b exp=000", ram_we, busy, done); end
      checks++; if ({rom_addr1, rom_addr2, ram_addr, ram_wdata, result} !== 25'h0) begin failures++; $display("FAIL rmid_outputs got=%h exp=0", {rom_addr1, rom_addr2, ram_addr, ram_wdata, result}); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      checks++; if (done_cnt != 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", done_cnt); end
      checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL rmid_wr_count got=%0d exp=2", wr_addr_q.size()); end
      if (wr_addr_q.size() == 2) begin
         checks++; if (wr_data_q[0] !== 8'h07 || wr_data_q[1] !== 8'h10 || rd1_q[0] !== 3'd6 || rd1_q[1] !== 3'd7) begin failures++; $display("FAIL rmid_writes got=%h,%h rd=%0d,%0d exp=07,10 rd=6,7", wr_data_q[0], wr_data_q[1], rd1_q[0], rd1_q[1]); end
      end
      do_start(3'd1, 3'd2, 3'd4, 4'd1);
      wait_done(20, ok);
      checks++; if (!ok || done_cyc != start_cyc + 5) begin failures++; $display("FAIL rmid_fresh_done got=%0d exp=%0d", done_cyc, start_cyc + 5); end
      checks++; if (wr_addr_q.size() != 1 || result !== 8'h06) begin failures++; $display("FAIL rmid_fresh_write got=%0d writes result=%h exp=1 writes 06", wr_addr_q.size(), result); end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [7:0] exp_w;
`ifdef MUL_SAT_EN
      exp_w = 8'hFF;
`else
      exp_w = 8'h00;
`endif
      rom_mem[3] = 8'h20;
      rom_mem[4] = 8'h10;
      do_start(3'd3, 3'd4, 3'd5, 4'd1);
      wait_done(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=no_done exp=done"); end
      checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL ovf_wr_count got=%0d exp=1", wr_addr_q.size()); end
      if (wr_addr_q.size() == 1) begin
         checks++; if (wr_addr_q[0] !== 3'd5 || wr_data_q[0] !== exp_w) begin failures++; $display("FAIL ovf_write got=%0d:%h exp=5:%h", wr_addr_q[0], wr_data_q[0], exp_w); end
`ifdef MUL_SAT_EN
         checks++; if (sat_q[0] !== 1'b1) begin failures++; $display("FAIL ovf_sat got=%b exp=1", sat_q[0]); end
`endif
      end
      checks++; if (result !== exp_w) begin failures++; $display("FAIL ovf_result got=%h exp=%h", result, exp_w); end
      rom_default();
   endtask

   // Hard stop in case something waits forever
   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Test sequence
   initial begin
      rom_default();
      test_reset();
      test_single_pair();
      test_wrap_batch();
      test_clamp();
      test_count_zero();
      test_ignored_start();
      test_reset_mid();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
